// File: rtl/periph_apb_bridge_pkg.sv
// periph_apb_bridge shared types and constants.
// Used by the bridge top and its optional timeout counter.
package periph_apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_br_state_e;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
    localparam int TO_CNT_W = 16;

endpackage

// File: rtl/periph_apb_bridge_timeout.sv
// Saturating ACCESS-phase wait counter for periph_apb_bridge.
// Present only when PERIPH_APB_BRIDGE_TIMEOUT_EN is defined.
module periph_apb_bridge_timeout
    import periph_apb_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic tick_i,
    output logic expired_o
);

    localparam logic [TO_CNT_W-1:0] LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] cnt_q;
    logic [TO_CNT_W-1:0] cnt_d;

    // Clear on entry to ACCESS, count stalled cycles, saturate at max.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This stalled cycle is the one that makes the count reach the limit.
    assign expired_o = tick_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/periph_apb_bridge.sv
// Single-outstanding request/grant to APB master bridge.
// Optional ACCESS timeout enabled by PERIPH_APB_BRIDGE_TIMEOUT_EN.
module periph_apb_bridge
    import periph_apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  r_valid_o,
    output logic [DATA_WIDTH-1:0] r_rdata_o,
    output logic                  r_err_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    apb_br_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;
    logic                  r_err_q, r_err_d;
    logic                  grant;
    logic                  expired;

    assign grant = req_i &&
        ((state_q == ST_IDLE) || (state_q == ST_RESP));

`ifdef PERIPH_APB_BRIDGE_TIMEOUT_EN
    periph_apb_bridge_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (state_q == ST_SETUP),
        .tick_i    ((state_q == ST_ACCESS) && !pready_i),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // Next state, request capture and response capture.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        r_rdata_d = r_rdata_q;
        r_err_d   = r_err_q;
        if (grant) begin
            paddr_d  = addr_i;
            pwdata_d = wdata_i;
            pwrite_d = we_i;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (grant) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    r_rdata_d = pwrite_q ? '0 : prdata_i;
                    r_err_d   = pslverr_i;
                    state_d   = ST_RESP;
                end else if (expired) begin
                    r_rdata_d = DATA_WIDTH'(ERR_RDATA);
                    r_err_d   = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = grant ? ST_SETUP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            r_rdata_q <= '0;
            r_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            r_rdata_q <= r_rdata_d;
            r_err_q   <= r_err_d;
        end
    end

    assign gnt_o     = grant;
    assign psel_o    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable_o = (state_q == ST_ACCESS);
    assign r_valid_o = (state_q == ST_RESP);
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign pwrite_o  = pwrite_q;
    assign r_rdata_o = r_rdata_q;
    assign r_err_o   = r_err_q;

endmodule

// File: tb/tb_periph_apb_bridge.sv
// Self-checking bench for periph_apb_bridge.
// Covers PERIPH_APB_BRIDGE_TIMEOUT_EN when that macro is defined.
module tb_periph_apb_bridge;

`ifdef PERIPH_APB_BRIDGE_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic        r_valid_o;
    logic [31:0] r_rdata_o;
    logic        r_err_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pwrite_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    periph_apb_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .addr_i    (addr_i),
        .we_i      (we_i),
        .wdata_i   (wdata_i),
        .r_valid_o (r_valid_o),
        .r_rdata_o (r_rdata_o),
        .r_err_o   (r_err_o),
        .paddr_o   (paddr_o),
        .pwdata_o  (pwdata_o),
        .pwrite_o  (pwrite_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer; the slave readies after `waits` stalled cycles.
    // Expected response follows the bridge rules: writes return 0,
    // reads return the slave data, error mirrors the ready-cycle pslverr.
    task automatic do_xfer(input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input int waits,
                           input logic [31:0] rd, input logic e);
        logic [31:0] exp_rd;
        exp_rd = w ? 32'h0 : rd;
        req_i = 1'b1; addr_i = a; we_i = w; wdata_i = wd;
        pready_i = 1'($urandom); pslverr_i = 1'($urandom);
        @(negedge clk);
        chk("gnt", gnt_o, 1);
        @(posedge clk); #1;
        req_i = 1'b0; addr_i = $urandom; wdata_i = $urandom;
        we_i = ~w;
        @(negedge clk);
        chk("setup_sel", {psel_o, penable_o}, 2'b10);
        chk("setup_addr", paddr_o, a);
        chk("setup_we", pwrite_o, w);
        chk("setup_wd", pwdata_o, wd);
        @(posedge clk); #1;
        for (int i = 0; i <= waits; i++) begin
            pready_i  = (i == waits);
            pslverr_i = (i == waits) ? e : 1'($urandom);
            prdata_i  = (i == waits) ? rd : $urandom;
            @(negedge clk);
            chk("acc_sel", {psel_o, penable_o}, 2'b11);
            chk("acc_addr", paddr_o, a);
            chk("acc_wd", pwdata_o, wd);
            chk("acc_we", pwrite_o, w);
            chk("acc_nv", r_valid_o, 0);
            @(posedge clk); #1;
        end
        pready_i = 1'b0;
        @(negedge clk);
        chk("resp_v", r_valid_o, 1);
        chk("resp_rd", r_rdata_o, exp_rd);
        chk("resp_err", r_err_o, e);
        chk("resp_sel", psel_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_v", r_valid_o, 0);
        chk("hold_rd", r_rdata_o, exp_rd);
        chk("hold_err", r_err_o, e);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0;
        wdata_i = '0; prdata_i = '0; pready_i = 1'b0;
        pslverr_i = 1'b0;
        @(negedge clk);
        chk("rst_outs",
            {gnt_o, r_valid_o, r_rdata_o, r_err_o, psel_o, penable_o},
            '0);
        chk("rst_apb", {paddr_o, pwdata_o}, '0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;

        do_xfer(32'h1A10_4000, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0);
        do_xfer(32'h1A10_1000, 1'b1, 32'hCAFE_F00D, 3, 32'h5555_AAAA,
                1'b0);
        do_xfer(32'h1A10_2004, 1'b0, 32'h0, 1, 32'h0BAD_0BAD, 1'b1);

        for (int n = 0; n < 10; n++) begin
            do_xfer($urandom, 1'($urandom), $urandom,
                    int'($urandom_range(0, 3)), $urandom,
                    1'($urandom));
        end

        // Back-to-back with req held and a zero-wait slave:
        // grants every third cycle, RESP doubles as the next grant slot.
        pready_i = 1'b1; prdata_i = 32'h7777_0001;
        for (int c = 0; c < 10; c++) begin
            req_i = (c < 7); addr_i = 32'h100 + c; we_i = 1'b0;
            @(negedge clk);
            chk("b2b_gnt", gnt_o, (c < 7) && (c % 3 == 0));
            chk("b2b_sel", psel_o, (c % 3) != 0);
            chk("b2b_v", r_valid_o, (c > 0) && (c % 3 == 0));
            @(posedge clk); #1;
        end
        req_i = 1'b0; pready_i = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of ACCESS aborts silently.
        req_i = 1'b1; addr_i = 32'h1A10_3000; we_i = 1'b0;
        @(posedge clk); #1;
        req_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_acc", {psel_o, penable_o}, 2'b11);
        #1 rst_i = 1'b1;
        #1;
        chk("abort_sel", {psel_o, penable_o}, 2'b00);
        chk("abort_v", r_valid_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0; pready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_nov", {r_valid_o, psel_o}, 2'b00);
            @(posedge clk); #1;
        end
        pready_i = 1'b0;
        do_xfer(32'h1A10_3004, 1'b0, 32'h0, 2, 32'hA5A5_5A5A, 1'b0);

`ifdef PERIPH_APB_BRIDGE_TIMEOUT_EN
        begin
            int acc;
            int cyc;
            acc = 0; cyc = 0;
            req_i = 1'b1; addr_i = 32'h1A10_9000; we_i = 1'b0;
            pready_i = 1'b0;
            @(posedge clk); #1;
            req_i = 1'b0;
            while (!r_valid_o && cyc < 40) begin
                @(negedge clk);
                if (penable_o) acc++;
                if (!r_valid_o) begin
                    @(posedge clk); #1;
                end
                cyc++;
            end
            chk("to_done", r_valid_o, 1);
            chk("to_acc", acc, TO);
            chk("to_err", r_err_o, 1);
            chk("to_rd", r_rdata_o, 32'hDEAD_BEEF);
            chk("to_sel", psel_o, 0);
            @(posedge clk); #1;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
